// File: rtl/instr_enc_32_if.sv
// instr_enc_32_if: request/response bundle for the instruction encoder.
// master: drives in_* request fields and out_ready; samples the rest.
// slave:  the encoder; drives in_ready, out_valid/out_instr/out_err, enc_count, err_count.
interface instr_enc_32_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;
    modport master (
        output in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
    modport slave (
        input  in_valid, in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_err, enc_count, err_count
    );
endinterface

// File: rtl/instr_enc_32.sv
// instr_enc_32: RV32 instruction encoder (R/I/S/B/U/J) feeding a DEPTH-entry output FIFO.
// Ports: clk, rst (sync, active-high); bus (instr_enc_32_if.slave) carries request,
// FIFO head and the enc/err counters. Optional macro IMM_RANGE_CHECK_EN flags
// out-of-range immediates as errors (encoding is still pushed, truncated).
module instr_enc_32 #(
    parameter int DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    instr_enc_32_if.slave bus
);
    localparam logic [2:0] INSTR_R = 3'd0;
    localparam logic [2:0] INSTR_I = 3'd1;
    localparam logic [2:0] INSTR_S = 3'd2;
    localparam logic [2:0] INSTR_B = 3'd3;
    localparam logic [2:0] INSTR_U = 3'd4;
    localparam logic [2:0] INSTR_J = 3'd5;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   imm;
    logic [31:0]   instr;
    logic          type_bad;
    logic          imm_bad;
    logic          err;
    logic          is_shift;
    logic          push;
    logic          pop;
    logic          full;
    logic [32:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   enc_q, enc_d, errc_q, errc_d;

    assign imm      = bus.in_imm;
    assign is_shift = bus.in_opcode == 7'b0010011 && (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101);

    always_comb begin
        instr    = '0;
        type_bad = 1'b0;
        case (bus.in_type)
            INSTR_R: instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            INSTR_I: instr = is_shift ? {bus.in_funct7, imm[4:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode}
                                      : {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            INSTR_S: instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], bus.in_opcode};
            INSTR_B: instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1], imm[11], bus.in_opcode};
            INSTR_U: instr = {imm[31:12], bus.in_rd, bus.in_opcode};
            INSTR_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            default: type_bad = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // Immediate must be representable by the format; branch/jump offsets must be even.
    always_comb begin
        imm_bad = 1'b0;
        case (bus.in_type)
            INSTR_I: imm_bad = is_shift ? imm[31:5] != '0 : imm[31:11] != {21{imm[11]}};
            INSTR_S: imm_bad = imm[31:11] != {21{imm[11]}};
            INSTR_B: imm_bad = imm[31:12] != {20{imm[12]}} || imm[0];
            INSTR_J: imm_bad = imm[31:20] != {12{imm[20]}} || imm[0];
            INSTR_U: imm_bad = imm[11:0] != '0;
            default: imm_bad = 1'b0;
        endcase
    end
`else
    assign imm_bad = 1'b0;
`endif

    assign err  = type_bad || imm_bad;
    assign full = cnt_q == CW'(DEPTH);
    // Ready ignores a same-cycle pop: no pass-through when full.
    assign bus.in_ready  = !full && !rst;
    assign bus.out_valid = cnt_q != '0 && !rst;
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    // Head is gated so nothing stale is visible while the FIFO is empty.
    assign bus.out_instr = bus.out_valid ? mem_q[rptr_q][31:0] : '0;
    assign bus.out_err   = bus.out_valid ? mem_q[rptr_q][32] : 1'b0;
    assign bus.enc_count = enc_q;
    assign bus.err_count = errc_q;

    always_comb begin
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        cnt_d  = cnt_q + CW'(push) - CW'(pop);
        enc_d  = push ? enc_q + 16'd1 : enc_q;
        errc_d = push && err && errc_q != 16'hFFFF ? errc_q + 16'd1 : errc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            enc_q  <= '0;
            errc_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            enc_q  <= enc_d;
            errc_q <= errc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {err, instr};
    end
endmodule
